// File: rtl/debug_cmd_sched.sv
// Command scheduler of the debugger unit: decodes UART command bytes and sequences
// the pipeline through fast-run, single-step and pipeline-reset modes.
module debug_cmd_sched #(
  parameter logic [7:0]  CMD_FAST   = 8'h46,
  parameter logic [7:0]  CMD_STEP   = 8'h53,
  parameter logic [7:0]  CMD_NEXT   = 8'h4E,
  parameter logic [7:0]  CMD_QUIT   = 8'h51,
  parameter logic [7:0]  CMD_RST    = 8'h52,
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned NB_CNT     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        i_rx_data,
  input  logic              is_rx_done,
  input  logic              is_stop_pipe,
  input  logic              is_fast_step,
  input  logic              is_fast_start_send,
  input  logic              is_fast_done,
  input  logic              is_done_send,
  output logic              os_fast_start,
  output logic              os_fast_done_send,
  output logic              os_send_start,
  output logic              os_pipe_en,
  output logic              os_pipe_rst_n,
  output logic              os_cmd_err,
  output logic              os_step_mode,
  output logic [NB_CNT-1:0] o_step_count
);

  localparam int unsigned RCW = $clog2(RST_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    RUN_FAST,
    STEP_IDLE,
    STEP_EXEC,
    STEP_SEND,
    STEP_WAIT,
    PIPE_RST
  } state_t;

  state_t            state, state_nxt;
  logic [RCW-1:0]    rst_cnt, rst_cnt_nxt;
  logic [NB_CNT-1:0] step_cnt_nxt;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of block ordering in simulation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      rst_cnt      <= '0;
      o_step_count <= '0;
    end else begin
      state        <= state_nxt;
      rst_cnt      <= rst_cnt_nxt;
      o_step_count <= step_cnt_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_nxt         = state;
    rst_cnt_nxt       = rst_cnt;
    step_cnt_nxt      = o_step_count;
    os_fast_start     = 1'b0;
    os_fast_done_send = 1'b0;
    os_send_start     = 1'b0;
    os_pipe_en        = 1'b0;
    os_pipe_rst_n     = 1'b1;
    os_cmd_err        = 1'b0;
    os_step_mode      = 1'b0;

    unique case (state)
      IDLE: begin
        if (is_rx_done) begin
          case (i_rx_data)
            CMD_FAST: begin
              os_fast_start = 1'b1;
              state_nxt     = RUN_FAST;
            end
            CMD_STEP: begin
              state_nxt    = STEP_IDLE;
              step_cnt_nxt = '0;
            end
            CMD_RST: begin
              state_nxt   = PIPE_RST;
              rst_cnt_nxt = RCW'(RST_CYCLES);
            end
            default: os_cmd_err = 1'b1;
          endcase
        end
      end

      RUN_FAST: begin
        os_pipe_en        = is_fast_step;
        os_send_start     = is_fast_start_send;
        os_fast_done_send = is_done_send;
        os_cmd_err        = is_rx_done;
        if (is_fast_done) state_nxt = IDLE;
      end

      STEP_IDLE: begin
        os_step_mode = 1'b1;
        if (is_rx_done) begin
          if (i_rx_data == CMD_NEXT && !is_stop_pipe) begin
            state_nxt = STEP_EXEC;
          end else if (i_rx_data == CMD_QUIT) begin
            state_nxt = IDLE;
          end else begin
            os_cmd_err = 1'b1;
          end
        end
      end

      STEP_EXEC: begin
        os_step_mode = 1'b1;
        os_pipe_en   = 1'b1;
        os_cmd_err   = is_rx_done;
        step_cnt_nxt = o_step_count + NB_CNT'(1);
        state_nxt    = STEP_SEND;
      end

      STEP_SEND: begin
        os_step_mode  = 1'b1;
        os_send_start = 1'b1;
        os_cmd_err    = is_rx_done;
        state_nxt     = STEP_WAIT;
      end

      STEP_WAIT: begin
        os_step_mode = 1'b1;
        os_cmd_err   = is_rx_done;
        if (is_done_send) state_nxt = is_stop_pipe ? IDLE : STEP_IDLE;
      end

      PIPE_RST: begin
        os_pipe_rst_n = 1'b0;
        os_cmd_err    = is_rx_done;
        // Counter holds the remaining low cycles including the current one.
        if (rst_cnt <= RCW'(1)) begin
          state_nxt   = IDLE;
          rst_cnt_nxt = '0;
        end else begin
          rst_cnt_nxt = rst_cnt - RCW'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
